// File: rtl/nn_pkg.sv
// Shared FP32 types, field positions and classification helpers for the NN pipeline.
package nn_pkg;

    typedef logic [31:0] fp32_t;

    localparam int FP_EXP_MSB      = 30;
    localparam int FP_EXP_LSB      = 23;
    localparam int FP_MAN_W        = 23;
    localparam int N_CLASS_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } argmax_state_t;

    function automatic logic is_nan(input fp32_t v);
        return (&v[FP_EXP_MSB:FP_EXP_LSB]) && (|v[FP_MAN_W-1:0]);
    endfunction

    // Sign is ignored so that +0 and -0 both classify as zero.
    function automatic logic is_zero(input fp32_t v);
        return ~|v[FP_EXP_MSB:0];
    endfunction

endpackage

// File: rtl/argmax_seq_if.sv
// Score stream plus control/result bundle between the dense-layer accumulator and readout.
interface argmax_seq_if #(
    parameter int IDX_W = 5
);
    import nn_pkg::*;

    logic             start;
    logic             score_valid;
    logic             score_ready;
    fp32_t            score;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] number;
    fp32_t            max_score;

    modport master (
        output start, score_valid, score,
        input  score_ready, busy, done, number, max_score
    );

    modport slave (
        input  start, score_valid, score,
        output score_ready, busy, done, number, max_score
    );

endinterface

// File: rtl/fp32_gt.sv
// Purpose: IEEE-754 single-precision strict greater-than (a > b); NaN operands never compare greater.
// Latency: combinational.
// Backpressure: none.
module fp32_gt
    import nn_pkg::*;
(
    input  fp32_t a,
    input  fp32_t b,
    output logic  gt
);

    always_comb begin
        gt = 1'b0;
        if (is_nan(a) || is_nan(b)) begin
            gt = 1'b0;
        end else if (is_zero(a) && is_zero(b)) begin
            gt = 1'b0;
        end else if (a[31] != b[31]) begin
            gt = ~a[31];
        end else if (!a[31]) begin
            gt = a[30:0] > b[30:0];
        end else begin
            // Sign-magnitude: among negatives the smaller magnitude is larger.
            gt = a[30:0] < b[30:0];
        end
    end

endmodule

// File: rtl/argmax_seq.sv
// Purpose: running FP32 argmax over N_CLASS streamed scores, one shared comparator.
// Latency: done pulses and result is final the cycle after the last accepted beat.
// Backpressure: none inside RUN (score_ready high throughout); scores outside RUN are ignored.
module argmax_seq
    import nn_pkg::*;
#(
    parameter int N_CLASS = N_CLASS_DEFAULT,
    parameter int IDX_W   = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    argmax_seq_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    argmax_state_t    state;
    logic [IDX_W-1:0] beat_cnt;
    logic [IDX_W-1:0] number_q;
    fp32_t            max_q;
    logic             have_max;
    logic             done_q;
    logic             busy_q;
    logic             rdy_q;

    logic             accept;
    logic             score_gt;
    logic             score_nan;
    logic             last_beat;

    fp32_gt u_gt (
        .a  (bus.score),
        .b  (max_q),
        .gt (score_gt)
    );

    assign accept    = bus.score_valid && rdy_q;
    assign score_nan = is_nan(bus.score);
    assign last_beat = (beat_cnt == LAST_IDX);

    assign bus.score_ready = rdy_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.number      = number_q;
    assign bus.max_score   = max_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            have_max <= 1'b0;
            number_q <= '0;
            max_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        beat_cnt <= '0;
                        have_max <= 1'b0;
                        busy_q   <= 1'b1;
                        rdy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        // A NaN may seed the slot but keeps have_max low so any real score replaces it.
                        if (!have_max) begin
                            number_q <= beat_cnt;
                            max_q    <= bus.score;
                            have_max <= ~score_nan;
                        end else if (!score_nan && score_gt) begin
                            number_q <= beat_cnt;
                            max_q    <= bus.score;
                        end
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            rdy_q  <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state    <= RUN;
                        beat_cnt <= '0;
                        have_max <= 1'b0;
                        busy_q   <= 1'b1;
                        rdy_q    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/argmax_seq.md
# argmax_seq

Sequential class selector for the NN inference pipeline. It takes the output layer's FP32 class scores as a stream, one score per accepted beat, and keeps a running maximum with an IEEE-754-aware comparator. After the last class it reports the winning index and its score. It sits between the final dense-layer accumulator and the result display/readout logic, and it replaces a wide combinational compare tree with a single comparator sequenced by a small FSM.

## Interface
Parameters:
- N_CLASS, 10: number of scores per inference.
- IDX_W, 5: width of the class index; must satisfy 2^IDX_W ≥ N_CLASS.

Ports:
- Clk, input, 1: single clock; all state updates on the rising edge.
- Reset, input, 1: reset is synchronous and active-high.
- start, input, 1: begin a new inference; sampled only in IDLE or DONE.
- score_valid, input, 1: score is valid this cycle.
- score_ready, output, 1: block accepts a score this cycle.
- score, input, 32: FP32 class score for index beat_cnt.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse when the result is valid.
- number, output, IDX_W: winning class index; held until the next start.
- max_score, output, 32: winning score; held with number.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start: clear beat_cnt, clear have_max.
  - RUN→DONE on the accepted beat where beat_cnt == N_CLASS-1.
  - DONE→IDLE unconditionally after one cycle, or DONE→RUN directly if start is high in DONE.
- Beat acceptance: a beat is accepted when score_valid && score_ready. score_ready = (state == RUN). beat_cnt increments only on accepted beats.
- Update rule per accepted beat:
  - If !have_max, or score is strictly greater than max_score (fp32_gt): load max_score ← score and number ← beat_cnt, then set have_max.
  - NaN scores (exp = 0xFF, mantissa ≠ 0) never load when have_max = 1. A NaN on beat 0 loads but leaves have_max = 0, so the next non-NaN beat replaces it.
- fp32_gt(a,b), for non-NaN operands:
  - Signs differ: the positive operand is greater, except +0 vs −0, which compare equal.
  - Both positive: greater {exp, mantissa} wins.
  - Both negative: smaller {exp, mantissa} wins.
  - Infinities use the same ordering.
- Ties: strict greater-than, so the lowest index wins.
- Start in RUN is ignored. score_valid outside RUN is ignored and no beat is consumed.
- Reset at any time, including mid-run: state = IDLE, beat_cnt = 0, have_max = 0, number = 0, max_score = 0, done = 0, busy = 0, score_ready = 0. A partial run is discarded.

## Timing
- Reset values: every output is 0.
- score_ready asserts the cycle after start is sampled (first cycle in RUN).
- Minimum run length is N_CLASS cycles with score_valid held high. The block applies no backpressure inside RUN; stalls come only from score_valid = 0.
- Latency: the last beat is accepted at edge t; done = 1 and number/max_score are final during cycle t+1 (DONE). done is low in all other cycles.
- number and max_score change only on accepted beats or on Reset; they stay stable through IDLE.
- Back-to-back runs: start high in DONE gives RUN in the next cycle, with no dead IDLE cycle.

## Structure
- Package nn_pkg holds:
  - typedef fp32_t (logic [31:0]).
  - Field constants FP_EXP_MSB=30, FP_EXP_LSB=23, FP_MAN_W=23.
  - N_CLASS_DEFAULT=10.
  - State enum argmax_state_t {IDLE, RUN, DONE}.
  - Functions is_nan and is_zero.
- One sub-module: fp32_gt, combinational, inputs a and b, output gt. It is shared with future pooling/activation blocks.
- The top level contains the FSM, beat counter, have_max flag, and the result registers.

## Test plan
- Ascending scores: beats 0–9 = 0x3DCCCCCD, except beat 7 = 0x40A00000 (5.0); valid held high → done at cycle 11 after start, number = 7, max_score = 0x40A00000.
- All negative: every beat = 0xBF800000 (−1.0), except beat 3 = 0xBF000000 (−0.5) → number = 3. Beat 0 = 0xFF800000 (−inf) with the rest −1.0 → number = 1.
- Tie and zeros: beats 2 and 5 = 0x40000000, the rest 0x3F800000 → number = 2. All beats ±0 (0x80000000 first, then 0x00000000) → number = 0.
- Gaps and NaN: score_valid toggled 1,0,1,… with beat 4 = 0x7FC00000 (NaN) and beat 9 = 0x41200000 → done exactly one cycle after the 10th accepted beat, number = 9. Beat 0 NaN with the rest equal 1.0 → number = 1.
- Reset mid-run: Reset asserted after 4 accepted beats → next cycle all outputs 0, busy = 0. A fresh start and 10 beats produce the correct result. start pulsed during RUN has no effect on beat count or result.
